// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the execute stage: two-cycle multiply,
// XLEN-cycle restoring divide, single-cycle fast paths for divide-by-zero and signed overflow.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_op;
  logic [XLEN:0]     r_mulA, r_mulB;
  logic [2*XLEN-1:0] r_product;
  logic [XLEN-1:0]   r_quot, r_rem, r_div, r_result;
  logic              r_negQ, r_negR;

  logic              w_accept, w_isDiv, w_signedDiv, w_divZero, w_overflow, w_fast, w_lastIter;
  logic [XLEN-1:0]   w_absA, w_absB;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN:0]     w_remShift, w_diff;
  logic [XLEN-1:0]   w_quotNext, w_remNext, w_quotFix, w_remFix;

  assign w_accept    = start && !flush && (r_state == IDLE || r_state == DONE);
  assign w_isDiv     = funct3[2];
  assign w_signedDiv = !funct3[0];
  assign w_divZero   = (SrcB == '0);
  assign w_overflow  = w_signedDiv && (SrcA == MIN_INT) && (SrcB == '1);
  assign w_fast      = w_divZero || w_overflow;
  assign w_lastIter  = (r_count == CW'(XLEN-1));

  assign w_absA = (w_signedDiv && SrcA[XLEN-1]) ? -SrcA : SrcA;
  assign w_absB = (w_signedDiv && SrcB[XLEN-1]) ? -SrcB : SrcB;

  // Operands are XLEN+1 bits with the sign already chosen per op, so the low 2*XLEN bits are exact.
  assign w_prod = {{(XLEN-1){r_mulA[XLEN]}}, r_mulA} * {{(XLEN-1){r_mulB[XLEN]}}, r_mulB};

  always_comb begin
    w_remShift = {r_rem, r_quot[XLEN-1]};
    w_diff     = w_remShift - {1'b0, r_div};
    w_remNext  = w_remShift[XLEN-1:0];
    w_quotNext = {r_quot[XLEN-2:0], 1'b0};
    if (!w_diff[XLEN]) begin
      w_remNext  = w_diff[XLEN-1:0];
      w_quotNext = {r_quot[XLEN-2:0], 1'b1};
    end
    w_quotFix = r_negQ ? -w_quotNext : w_quotNext;
    w_remFix  = r_negR ? -w_remNext : w_remNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          w_next = IDLE;
          if (start) begin
            if (!w_isDiv)    w_next = MUL;
            else if (w_fast) w_next = DONE;
            else             w_next = DIV;
          end
        end
        MUL:     w_next = DONE;
        DIV:     if (w_lastIter) w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  assign busy   = (r_state == MUL) || (r_state == DIV);
  assign done   = (r_state == DONE);
  assign result = r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_op      <= '0;
      r_mulA    <= '0;
      r_mulB    <= '0;
      r_product <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_result  <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_op    <= funct3[1:0];
      r_count <= '0;
      if (!w_isDiv) begin
        r_mulA <= {(funct3[1:0] != 2'b11) && SrcA[XLEN-1], SrcA};
        r_mulB <= {(funct3[1:0] == 2'b01) && SrcB[XLEN-1], SrcB};
      end else if (w_fast) begin
        if (w_divZero) r_result <= funct3[1] ? SrcA : '1;
        else           r_result <= funct3[1] ? '0 : MIN_INT;
      end else begin
        r_quot <= w_absA;
        r_div  <= w_absB;
        r_rem  <= '0;
        r_negQ <= w_signedDiv && (SrcA[XLEN-1] ^ SrcB[XLEN-1]);
        r_negR <= w_signedDiv && SrcA[XLEN-1];
      end
    end else begin
      unique case (r_state)
        MUL: begin
          r_product <= w_prod;
          r_result  <= (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
        DIV: begin
          r_quot <= w_quotNext;
          r_rem  <= w_remNext;
          if (w_lastIter) begin
            r_count  <= '0;
            r_result <= r_op[1] ? w_remFix : w_quotFix;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: an execute-stage M-extension instruction is presented this cycle.
REQ-005 The block SHALL have port funct3, input, 3 bits: operation select.
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-006 The block SHALL have port SrcA, input, XLEN bits: forwarded rs1 operand (dividend or multiplicand).
REQ-007 The block SHALL have port SrcB, input, XLEN bits: forwarded rs2 operand (divisor or multiplier).
REQ-008 The block SHALL have port flush, input, 1 bit: the hazard unit kills the instruction in execute.
REQ-009 The block SHALL have port busy, output, 1 bit: an operation is in flight; the hazard unit stalls fetch, decode and execute.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse; result is valid and feeds the EX/MEM ALUResult path.
REQ-011 The block SHALL have port result, output, XLEN bits: operation result.

Function
REQ-012 The block SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-013 A start SHALL be accepted only in IDLE or DONE with flush low; start SHALL be ignored in MUL and DIV.
REQ-014 On an accepted multiply in cycle N, the block SHALL:
- latch the operands with sign-extension per funct3 into a 2*XLEN product register;
- enter MUL in N+1;
- enter DONE with done=1 in N+2.
REQ-015 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits (signed x signed, signed x unsigned, unsigned x unsigned).
REQ-016 On an accepted divide in cycle N with a normal case, the block SHALL:
- take absolute values if funct3 is signed;
- run XLEN restoring-shift iterations, one per cycle, in DIV under a counter running 0..XLEN-1;
- apply sign fixup in the DONE transition;
- assert done in cycle N+XLEN+1 (N+33 for XLEN=32).
REQ-017 Signed quotient SHALL be negative iff the operand signs differ; signed remainder SHALL take the dividend's sign.
REQ-018 Divide by zero SHALL take a fast path with done in N+1: quotient all ones, remainder = SrcA.
REQ-019 Signed overflow (SrcA = 0x80000000, SrcB = 0xFFFFFFFF, DIV/REM) SHALL take a fast path with done in N+1: quotient 0x80000000, remainder 0.
REQ-020 busy SHALL be 1 from cycle N+1 through the cycle before done, and 0 in the done cycle and in IDLE.
- Fast-path operations never raise busy.
REQ-021 DONE SHALL last exactly one cycle, then the block SHALL return to IDLE unless a new start is accepted in that cycle, in which case it SHALL follow REQ-014/016.
REQ-022 result SHALL hold its value from the done cycle until the next done; it SHALL not glitch during iterations.
REQ-023 flush SHALL force IDLE on the next edge, from any state, with done=0 and busy=0.
- result SHALL be unchanged.
- flush has priority over start in the same cycle.
REQ-024 The counter SHALL wrap only via the state change to DONE; it SHALL not free-run in IDLE.

Reset
REQ-025 Asserting reset SHALL immediately set: state IDLE, busy 0, done 0, result 0, counter 0, product/quotient/remainder registers 0.
REQ-026 Reset asserted mid-operation SHALL abandon the operation with no done pulse after release.
REQ-027 The first start SHALL be accepted on the first rising edge with reset low.

Verification
REQ-028 MUL SrcA=7, SrcB=-3 (0xFFFFFFFD) -> done at N+2, result 0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 DIV -7 / 2 -> busy N+1..N+32, done N+33, result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-030 DIVU 100 / 0 -> done N+1, busy never set, result 0xFFFFFFFF; REMU 100 / 0 -> result 100.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> done N+1, result 0x80000000; REM -> 0.
REQ-032 DIVU started, flush at N+10 -> IDLE at N+11, no done, result keeps the prior value; a new MUL at N+12 completes at N+14.
REQ-033 Reset at N+5 of a DIV -> outputs zero immediately, no done after release; back-to-back start in the DONE cycle is accepted with correct latency.
